wb_stage: RTL and testbench

- Writeback stage sitting directly upstream of the general-purpose register file.
- Accepts one retiring instruction per handshake from the execute/memory stage and waits for the data-memory response when the instruction is a load.
- Formats load data: byte/halfword select plus sign/zero extension.
- Drives the register-file write port as a registered single-cycle pulse, together with commit information (instruction, PC) and load-busy/hazard information for the upstream stage.

---
 rtl/wb_stage.sv | 203 ++++++++++++++++++++
 tb/tb_wb_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : Writeback stage in front of the GPR file. Retires one
//             instruction per handshake. ALU results are written back one
//             cycle after accept. Loads wait for the data-memory response,
//             then select the byte or halfword and sign/zero extend it.
//             Produces a registered register-file write pulse, commit
//             information and load-hazard information for upstream.
//  Options  : WB_TIMEOUT_EN - abandon a load after TIMEOUT_CYCLES cycles
//             without a memory response (error + commit, no write).
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [31:0] I_inst,
  input  logic [31:0] I_inst_addr,
  input  logic        I_rd_we,
  input  logic [4:0]  I_rd_waddr,
  input  logic [31:0] I_alu_result,
  input  logic        I_is_load,
  input  logic [2:0]  I_load_funct3,
  input  logic [1:0]  I_addr_lo,
  input  logic        I_mem_rvalid,
  input  logic [31:0] I_mem_rdata,
  output logic        O_rd_we,
  output logic [4:0]  O_rd_waddr,
  output logic [31:0] O_rd_wdata,
  output logic        O_commit_valid,
  output logic [31:0] O_commit_inst,
  output logic [31:0] O_commit_pc,
  output logic        O_load_busy,
  output logic [4:0]  O_load_rd,
  output logic        O_err
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;

  // Reject parameter combinations the timeout counter cannot represent.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || CNT_W < 1 || CNT_W > 32 ||
      (64'(1) << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_param_check
    $error("wb_stage: illegal TIMEOUT_CYCLES/CNT_W combination");
  end

  logic [0:0]  state;
  logic [31:0] cap_inst;
  logic [31:0] cap_pc;
  logic        cap_rd_we;
  logic [4:0]  cap_rd;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_addr_lo;

  logic        accept;
  logic        accept_load;
  logic        mem_resp;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] fmt_data;
  logic        fmt_legal;
  logic        timeout_hit;

  assign O_ready     = (state == S_IDLE);
  assign accept      = I_valid & O_ready;
  assign accept_load = accept & I_is_load;
  // A response only counts while a load is outstanding; in IDLE it is ignored.
  assign mem_resp    = (state == S_WAIT_MEM) & I_mem_rvalid;

  assign O_load_busy = (state == S_WAIT_MEM);
  assign O_load_rd   = (O_load_busy && cap_rd_we) ? cap_rd : 5'd0;

`ifdef WB_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Expiry is the WAIT_MEM cycle whose missing response would bring the
  // count to TIMEOUT_CYCLES; a response in that cycle takes priority.
  assign timeout_hit = (state == S_WAIT_MEM) && !I_mem_rvalid &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count WAIT_MEM cycles spent without a memory response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (accept_load) begin
      wait_cnt <= '0;
    end else if ((state == S_WAIT_MEM) && !I_mem_rvalid) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Load data formatting: lane select by the captured low address bits.
  always_comb begin
    byte_sel  = 8'h00;
    fmt_data  = 32'h0000_0000;
    fmt_legal = 1'b1;
    case (cap_addr_lo)
      2'd0:    byte_sel = I_mem_rdata[7:0];
      2'd1:    byte_sel = I_mem_rdata[15:8];
      2'd2:    byte_sel = I_mem_rdata[23:16];
      default: byte_sel = I_mem_rdata[31:24];
    endcase
    half_sel = cap_addr_lo[1] ? I_mem_rdata[31:16] : I_mem_rdata[15:0];
    case (cap_funct3)
      3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  fmt_data = I_mem_rdata;
      3'b100:  fmt_data = {24'h000000, byte_sel};
      3'b101:  fmt_data = {16'h0000, half_sel};
      default: fmt_legal = 1'b0;
    endcase
  end

  // Capture the fields of an accepted load for use when the response arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_inst    <= 32'h0000_0000;
      cap_pc      <= 32'h0000_0000;
      cap_rd_we   <= 1'b0;
      cap_rd      <= 5'd0;
      cap_funct3  <= 3'd0;
      cap_addr_lo <= 2'd0;
    end else if (accept_load) begin
      cap_inst    <= I_inst;
      cap_pc      <= I_inst_addr;
      cap_rd_we   <= I_rd_we;
      cap_rd      <= I_rd_waddr;
      cap_funct3  <= I_load_funct3;
      cap_addr_lo <= I_addr_lo;
    end
  end

  // State sequencing plus registered writeback/commit/error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      O_rd_we        <= 1'b0;
      O_rd_waddr     <= 5'd0;
      O_rd_wdata     <= 32'h0000_0000;
      O_commit_valid <= 1'b0;
      O_commit_inst  <= 32'h0000_0000;
      O_commit_pc    <= 32'h0000_0000;
      O_err          <= 1'b0;
    end else begin
      O_rd_we        <= 1'b0;
      O_commit_valid <= 1'b0;
      O_err          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (I_is_load) begin
              state <= S_WAIT_MEM;
            end else begin
              // Write data/address track every rd-writing op (x0 included)
              // so the port shows the value even when the enable is masked.
              O_rd_we        <= I_rd_we & (I_rd_waddr != 5'd0);
              if (I_rd_we) begin
                O_rd_waddr <= I_rd_waddr;
                O_rd_wdata <= I_alu_result;
              end
              O_commit_valid <= 1'b1;
              O_commit_inst  <= I_inst;
              O_commit_pc    <= I_inst_addr;
            end
          end
        end
        default: begin
          if (mem_resp) begin
            state          <= S_IDLE;
            O_commit_valid <= 1'b1;
            O_commit_inst  <= cap_inst;
            O_commit_pc    <= cap_pc;
            if (fmt_legal) begin
              O_rd_we <= cap_rd_we & (cap_rd != 5'd0);
              if (cap_rd_we) begin
                O_rd_waddr <= cap_rd;
                O_rd_wdata <= fmt_data;
              end
            end else begin
              O_err <= 1'b1;
            end
          end else if (timeout_hit) begin
            state          <= S_IDLE;
            O_commit_valid <= 1'b1;
            O_commit_inst  <= cap_inst;
            O_commit_pc    <= cap_pc;
            O_err          <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Self-checking bench for wb_stage. Table of ALU/load vectors
//             with a commit scoreboard, plus hand sequences for back-to-back
//             retirement, idle responses, reset mid-load and load timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        I_valid = 1'b0;
  logic        O_ready;
  logic [31:0] I_inst = '0;
  logic [31:0] I_inst_addr = '0;
  logic        I_rd_we = 1'b0;
  logic [4:0]  I_rd_waddr = '0;
  logic [31:0] I_alu_result = '0;
  logic        I_is_load = 1'b0;
  logic [2:0]  I_load_funct3 = '0;
  logic [1:0]  I_addr_lo = '0;
  logic        I_mem_rvalid = 1'b0;
  logic [31:0] I_mem_rdata = 32'hDEAD_BEEF;
  logic        O_rd_we;
  logic [4:0]  O_rd_waddr;
  logic [31:0] O_rd_wdata;
  logic        O_commit_valid;
  logic [31:0] O_commit_inst;
  logic [31:0] O_commit_pc;
  logic        O_load_busy;
  logic [4:0]  O_load_rd;
  logic        O_err;

  wb_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .I_valid(I_valid), .O_ready(O_ready),
    .I_inst(I_inst), .I_inst_addr(I_inst_addr), .I_rd_we(I_rd_we),
    .I_rd_waddr(I_rd_waddr), .I_alu_result(I_alu_result), .I_is_load(I_is_load),
    .I_load_funct3(I_load_funct3), .I_addr_lo(I_addr_lo),
    .I_mem_rvalid(I_mem_rvalid), .I_mem_rdata(I_mem_rdata),
    .O_rd_we(O_rd_we), .O_rd_waddr(O_rd_waddr), .O_rd_wdata(O_rd_wdata),
    .O_commit_valid(O_commit_valid), .O_commit_inst(O_commit_inst),
    .O_commit_pc(O_commit_pc), .O_load_busy(O_load_busy), .O_load_rd(O_load_rd),
    .O_err(O_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        rwe;
    logic [4:0]  rd;
    logic [31:0] val;      // ALU result or memory read word
    int          dly;      // idle WAIT_MEM cycles before the response
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        chk_data; // write address/data expected to update
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        chk;
    logic        err;
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[17];
  int   total = 0;
  int   bad = 0;
  int   commits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard: every commit pops the oldest expected retirement.
  always @(negedge clk) begin
    if (O_commit_valid) begin
      commits++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit: pc 0x%08h with nothing pending", O_commit_pc);
      end else begin
        mon_e = sb.pop_front();
        check("rd_we", {31'd0, O_rd_we}, {31'd0, mon_e.we});
        check("err", {31'd0, O_err}, {31'd0, mon_e.err});
        check("commit_inst", O_commit_inst, mon_e.inst);
        check("commit_pc", O_commit_pc, mon_e.pc);
        if (mon_e.chk) begin
          check("rd_waddr", {27'd0, O_rd_waddr}, {27'd0, mon_e.waddr});
          check("rd_wdata", O_rd_wdata, mon_e.wdata);
        end
      end
    end else if (O_rd_we || O_err) begin
      total++;
      bad++;
      $display("FAIL stray_pulse: rd_we=%0b err=%0b without commit", O_rd_we, O_err);
    end
  end

  // Apply one vector from IDLE (called at posedge+1) and check its timing.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    I_valid       = 1'b1;
    I_inst        = 32'h1000_0000 + 32'(idx);
    I_inst_addr   = 32'h8000_0000 + 32'(idx) * 4;
    I_rd_we       = v.rwe;
    I_rd_waddr    = v.rd;
    I_alu_result  = v.is_load ? 32'h5A5A_5A5A : v.val;
    I_is_load     = v.is_load;
    I_load_funct3 = v.f3;
    I_addr_lo     = v.lo;
    e = '{v.exp_we, v.rd, v.exp_data, v.chk_data, v.exp_err, I_inst, I_inst_addr};
    sb.push_back(e);
    @(posedge clk); #1;
    I_valid = 1'b0;
    if (v.is_load) begin
      for (int c = 0; c <= v.dly; c++) begin
        check("ready_in_wait", {31'd0, O_ready}, 32'd0);
        check("load_busy", {31'd0, O_load_busy}, 32'd1);
        check("load_rd", {27'd0, O_load_rd}, v.rwe ? {27'd0, v.rd} : 32'd0);
        if (c == v.dly) begin
          I_mem_rvalid = 1'b1;
          I_mem_rdata  = v.val;
        end
        @(posedge clk); #1;
      end
      I_mem_rvalid = 1'b0;
      I_mem_rdata  = 32'hDEAD_BEEF;
    end
    check("ready_after", {31'd0, O_ready}, 32'd1);
    @(negedge clk); #1;
    check("retire_latency", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int stuck;
    exp_t e;
    //           ld f3     lo    rwe rd     val            dly we data           err chk
    vecs[0]  = '{0, 3'b000, 2'd0, 1, 5'd5,  32'h1234_5678, 0, 1, 32'h1234_5678, 0, 1};
    vecs[1]  = '{0, 3'b000, 2'd0, 1, 5'd0,  32'hAAAA_5555, 0, 0, 32'hAAAA_5555, 0, 1};
    vecs[2]  = '{0, 3'b000, 2'd0, 0, 5'd7,  32'h0BAD_0BAD, 0, 0, 32'h0,         0, 0};
    vecs[3]  = '{1, 3'b000, 2'd3, 1, 5'd10, 32'h80FF_1234, 3, 1, 32'hFFFF_FF80, 0, 1};
    vecs[4]  = '{1, 3'b100, 2'd3, 1, 5'd10, 32'h80FF_1234, 3, 1, 32'h0000_0080, 0, 1};
    vecs[5]  = '{1, 3'b000, 2'd0, 1, 5'd11, 32'h80FF_1234, 0, 1, 32'h0000_0034, 0, 1};
    vecs[6]  = '{1, 3'b000, 2'd2, 1, 5'd12, 32'h80FF_1234, 1, 1, 32'hFFFF_FFFF, 0, 1};
    vecs[7]  = '{1, 3'b100, 2'd1, 1, 5'd13, 32'h80FF_1234, 2, 1, 32'h0000_0012, 0, 1};
    vecs[8]  = '{1, 3'b001, 2'd2, 1, 5'd14, 32'hBEEF_7FFF, 0, 1, 32'hFFFF_BEEF, 0, 1};
    vecs[9]  = '{1, 3'b101, 2'd0, 1, 5'd15, 32'hBEEF_7FFF, 1, 1, 32'h0000_7FFF, 0, 1};
    vecs[10] = '{1, 3'b010, 2'd1, 1, 5'd16, 32'hBEEF_7FFF, 2, 1, 32'hBEEF_7FFF, 0, 1};
    vecs[11] = '{1, 3'b001, 2'd0, 1, 5'd17, 32'hBEEF_7FFF, 0, 1, 32'h0000_7FFF, 0, 1};
    vecs[12] = '{1, 3'b101, 2'd3, 1, 5'd18, 32'hBEEF_7FFF, 0, 1, 32'h0000_BEEF, 0, 1};
    vecs[13] = '{1, 3'b011, 2'd0, 1, 5'd9,  32'h1111_2222, 1, 0, 32'h0,         1, 0};
    vecs[14] = '{1, 3'b111, 2'd0, 1, 5'd9,  32'h1111_2222, 0, 0, 32'h0,         1, 0};
    vecs[15] = '{1, 3'b010, 2'd0, 1, 5'd0,  32'hBEEF_7FFF, 1, 0, 32'hBEEF_7FFF, 0, 1};
    vecs[16] = '{1, 3'b000, 2'd0, 0, 5'd20, 32'h80FF_1234, 2, 0, 32'h0,         0, 0};

    // Reset state
    #12;
    check("rst_ready", {31'd0, O_ready}, 32'd1);
    check("rst_rd_we", {31'd0, O_rd_we}, 32'd0);
    check("rst_commit", {31'd0, O_commit_valid}, 32'd0);
    check("rst_err", {31'd0, O_err}, 32'd0);
    check("rst_busy", {31'd0, O_load_busy}, 32'd0);
    check("rst_load_rd", {27'd0, O_load_rd}, 32'd0);
    check("rst_wdata", O_rd_wdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Three back-to-back ALU ops retire on consecutive cycles.
    c0 = commits;
    for (int k = 0; k < 3; k++) begin
      I_valid = 1'b1; I_is_load = 1'b0; I_rd_we = 1'b1;
      I_rd_waddr = 5'(21 + k); I_alu_result = 32'hC0DE_0000 + 32'(k);
      I_inst = 32'h2000_0000 + 32'(k); I_inst_addr = 32'h8000_1000 + 32'(k) * 4;
      e = '{1'b1, I_rd_waddr, I_alu_result, 1'b1, 1'b0, I_inst, I_inst_addr};
      sb.push_back(e);
      @(posedge clk); #1;
      check("b2b_commit", {31'd0, O_commit_valid}, 32'd1);
    end
    I_valid = 1'b0;
    @(negedge clk); #1;
    check("b2b_count", 32'(commits - c0), 32'd3);
    @(posedge clk); #1;

    // Memory response while idle is ignored.
    c0 = commits;
    I_mem_rvalid = 1'b1; I_mem_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 I_mem_rvalid = 1'b0;
    @(negedge clk); #1;
    check("idle_rvalid_commits", 32'(commits - c0), 32'd0);
    check("idle_rvalid_ready", {31'd0, O_ready}, 32'd1);
    @(posedge clk); #1;

    // Reset during WAIT_MEM abandons the load.
    I_valid = 1'b1; I_is_load = 1'b1; I_rd_we = 1'b1; I_rd_waddr = 5'd3;
    I_load_funct3 = 3'b010; I_inst = 32'h3000_0000; I_inst_addr = 32'h8000_2000;
    @(posedge clk); #1;
    I_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", {31'd0, O_load_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rd_we", {31'd0, O_rd_we}, 32'd0);
    check("mid_rst_busy", {31'd0, O_load_busy}, 32'd0);
    check("mid_rst_ready", {31'd0, O_ready}, 32'd1);
    check("mid_rst_load_rd", {27'd0, O_load_rd}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    c0 = commits;
    @(posedge clk); #1;
    I_mem_rvalid = 1'b1; I_mem_rdata = 32'h7777_7777;
    repeat (2) @(posedge clk);
    #1 I_mem_rvalid = 1'b0;
    @(negedge clk); #1;
    check("late_rvalid_commits", 32'(commits - c0), 32'd0);
    @(posedge clk); #1;

    // Load with no response.
    I_valid = 1'b1; I_is_load = 1'b1; I_rd_we = 1'b1; I_rd_waddr = 5'd4;
    I_load_funct3 = 3'b010; I_inst = 32'h4000_0000; I_inst_addr = 32'h8000_3000;
`ifdef WB_TIMEOUT_EN
    e = '{1'b0, 5'd4, 32'd0, 1'b0, 1'b1, I_inst, I_inst_addr};
    sb.push_back(e);
    @(posedge clk); #1;
    I_valid = 1'b0;
    for (int c = 0; c < TO; c++) begin
      check("to_busy", {31'd0, O_load_busy}, 32'd1);
      @(posedge clk); #1;
    end
    check("to_ready", {31'd0, O_ready}, 32'd1);
    @(negedge clk); #1;
    check("to_retire", 32'(sb.size()), 32'd0);
`else
    @(posedge clk); #1;
    I_valid = 1'b0;
    stuck = 0;
    for (int c = 0; c < 1000; c++) begin
      if (!O_load_busy || O_ready || O_commit_valid) stuck++;
      @(posedge clk); #1;
    end
    check("wait_forever", 32'(stuck), 32'd0);
    e = '{1'b1, 5'd4, 32'hBEEF_7FFF, 1'b1, 1'b0, I_inst, I_inst_addr};
    sb.push_back(e);
    I_mem_rvalid = 1'b1; I_mem_rdata = 32'hBEEF_7FFF;
    @(posedge clk); #1;
    I_mem_rvalid = 1'b0;
    @(negedge clk); #1;
    check("late_drain", 32'(sb.size()), 32'd0);
`endif
    @(posedge clk); #1;
    check("final_pending", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
